// File: rtl/spi_rx_pkg.sv
// Shared types and default sizes for the SPI receive front end.
package spi_rx_pkg;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_FIFO_DEPTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth; head word readable without a pop.
module sync_fifo
   import spi_rx_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              w_do_push;
   logic              w_do_pop;

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & (~full | w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_level <= r_level + LW'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_level <= r_level - LW'(1);
         end
      end
   end

   assign full     = (r_level == LW'(DEPTH));
   assign empty    = (r_level == '0);
   assign level    = r_level;
   assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/spi_rx_frontend.sv
// SPI mode-0 slave receiver: synchronizers, bit FSM, byte FIFO.
// Optional MISO echo of the previous byte when SPI_RX_ECHO_EN is defined.
module spi_rx_frontend
   import spi_rx_pkg::*;
#(
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int DATA_W     = DEF_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          spi_sclk,
   input  logic                          spi_cs_n,
   input  logic                          spi_mosi,
   output logic                          spi_miso,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int             CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_W - 1);

   logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic r_cs_meta, r_cs_sync;
   logic r_mosi_meta, r_mosi_sync;
   logic w_sclk_rise;

   state_t            r_state, w_state_next;
   logic              w_shift_en, w_abort;
   logic [CW-1:0]     r_bit_cnt;
   logic [DATA_W-1:0] r_shift, w_shift_next;
   logic              w_byte_done;
   logic              r_overflow, r_frame_err;
   logic              w_full, w_empty, w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_sclk_meta <= spi_sclk;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_cs_meta   <= spi_cs_n;
         r_cs_sync   <= r_cs_meta;
         r_mosi_meta <= spi_mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (!r_cs_sync) w_state_next = SHIFT;
         SHIFT:   if (r_cs_sync)  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // A deselect seen in the same cycle as a rise wins: the bit is not taken.
   always_comb begin
      w_shift_en = 1'b0;
      w_abort    = 1'b0;
      if (r_state == SHIFT) begin
         w_shift_en = ~r_cs_sync & w_sclk_rise;
         w_abort    = r_cs_sync & (r_bit_cnt != '0);
      end
   end

   assign w_shift_next = {r_shift[DATA_W-2:0], r_mosi_sync};
   assign w_byte_done  = w_shift_en & (r_bit_cnt == CNT_LAST);
   assign w_pop        = rx_ready & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_frame_err <= w_abort;
         if (w_abort || (r_state == IDLE)) begin
            r_bit_cnt <= '0;
         end else if (w_shift_en) begin
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_byte_done ? '0 : r_bit_cnt + CW'(1);
         end
         if (w_byte_done && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_byte_done),
      .push_data (w_shift_next),
      .pop       (rx_ready),
      .pop_data  (rx_data),
      .full      (w_full),
      .empty     (w_empty),
      .level     (fifo_level)
   );

   assign rx_valid  = ~w_empty;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

`ifdef SPI_RX_ECHO_EN
   logic              w_sclk_fall;
   logic [DATA_W-1:0] r_echo, r_tx;
   logic              r_miso;

   assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;

   // Between frames the MSB is parked on MISO so it is valid before the first rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_echo <= '0;
         r_tx   <= '0;
         r_miso <= 1'b0;
      end else if (r_state == IDLE) begin
         r_tx   <= {r_echo[DATA_W-2:0], 1'b0};
         r_miso <= r_echo[DATA_W-1];
      end else if (w_byte_done) begin
         r_echo <= w_shift_next;
         r_tx   <= w_shift_next;
      end else if (w_sclk_fall) begin
         r_miso <= r_tx[DATA_W-1];
         r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
   end

   assign spi_miso = r_miso;
`else
   assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Bench for spi_rx_frontend: queue-based reference model plus directed SPI frames.
module tb_spi_rx_frontend;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic                     clk      = 1'b0;
   logic                     rst      = 1'b1;
   logic                     spi_sclk = 1'b0;
   logic                     spi_cs_n = 1'b1;
   logic                     spi_mosi = 1'b0;
   logic                     rx_ready = 1'b0;
   logic                     spi_miso;
   logic [DW-1:0]            rx_data;
   logic                     rx_valid;
   logic [$clog2(DEPTH):0]   fifo_level;
   logic                     overflow;
   logic                     frame_err;

   always #5 clk = ~clk;

   spi_rx_frontend #(
      .FIFO_DEPTH (DEPTH),
      .DATA_W     (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pins seen two clocks late, bits taken on synced rises while selected.
   logic [7:0] mq[$];
   bit         m_ovf, m_ferr, started;
   int         m_cnt;
   logic [7:0] m_sh;
   bit [2:0]   h_s, h_c, h_m;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_ferr = 0; m_cnt = 0; m_sh = '0;
         h_s = 3'b000; h_c = 3'b111; h_m = 3'b000;
         started = 1;
      end else begin
         m_ferr = 0;
         if (rx_ready && mq.size() > 0) void'(mq.pop_front());
         if (!h_c[1] && !h_c[2] && h_s[1] && !h_s[2]) begin
            m_sh = {m_sh[6:0], h_m[1]};
            m_cnt++;
            if (m_cnt == DW) begin
               m_cnt = 0;
               if (mq.size() < DEPTH) mq.push_back(m_sh);
               else m_ovf = 1;
            end
         end
         if (h_c[1] && !h_c[2]) begin
            if (m_cnt != 0) m_ferr = 1;
            m_cnt = 0;
         end
         h_s = {h_s[1:0], spi_sclk};
         h_c = {h_c[1:0], spi_cs_n};
         h_m = {h_m[1:0], spi_mosi};
      end
   end

   int         n_valid_cyc = 0;
   int         n_ferr = 0;
   logic [7:0] pop_log[$];
   logic [7:0] exp_log[$];

   always @(negedge clk) begin
      if (started) begin
         chk("level", 32'(fifo_level), mq.size());
         chk("valid", 32'(rx_valid), 32'(mq.size() != 0));
         if (mq.size() != 0) chk("data", 32'(rx_data), 32'(mq[0]));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("frame_err", 32'(frame_err), 32'(m_ferr));
`ifndef SPI_RX_ECHO_EN
         chk("miso", 32'(spi_miso), 32'h0);
`endif
         n_valid_cyc += int'(rx_valid);
         n_ferr      += int'(frame_err);
      end
   end

   always @(posedge clk) begin
      if (!rst && rx_valid && rx_ready) begin
         pop_log.push_back(rx_data);
         $display("pop  data=0x%02h level=%0d t=%0t", rx_data, fifo_level, $time);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b);
      spi_mosi = b;
      tick(4);
      spi_sclk = 1'b1;
      tick(4);
      spi_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic send_byte_cap(input logic [7:0] b, output logic [7:0] cap);
      cap = '0;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = b[i];
         tick(4);
         cap = {cap[6:0], spi_miso};
         spi_sclk = 1'b1;
         tick(4);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      tick(8);
   endtask

   task automatic cs_end();
      tick(4);
      spi_cs_n = 1'b1;
      tick(10);
   endtask

   task automatic check_log(input string name);
      chk({name, "_count"}, pop_log.size(), exp_log.size());
      foreach (exp_log[i])
         chk($sformatf("%s_%0d", name, i),
             (i < pop_log.size()) ? {24'h0, pop_log[i]} : 32'hxxxx_xxxx,
             {24'h0, exp_log[i]});
      pop_log.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_level"}, 32'(fifo_level), 32'h0);
      chk({name, "_valid"}, 32'(rx_valid), 32'h0);
      chk({name, "_data"}, 32'(rx_data), 32'h0);
      chk({name, "_ovf"}, 32'(overflow), 32'h0);
      chk({name, "_ferr"}, 32'(frame_err), 32'h0);
      chk({name, "_miso"}, 32'(spi_miso), 32'h0);
   endtask

   initial begin
      int         v0, f0;
      logic [7:0] cap;
      logic [7:0] exp_echo;

      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(2);

      // Single byte, consumer always ready
      rx_ready = 1'b1;
      pop_log.delete();
      v0 = n_valid_cyc;
      cs_begin();
      send_byte(8'hA5);
      cs_end();
      chk("a5_valid_cycles", n_valid_cyc - v0, 1);
      exp_log = {8'hA5};
      check_log("a5");

      // Aborted partial byte, then a clean byte
      f0 = n_ferr;
      cs_begin();
      spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
      cs_end();
      chk("abort_ferr_pulses", n_ferr - f0, 1);
      chk("abort_level", 32'(fifo_level), 32'h0);
      cs_begin();
      send_byte(8'h3C);
      cs_end();
      exp_log = {8'h3C};
      check_log("after_abort");

      // Overflow: five bytes into a four-deep FIFO with no consumer
      rx_ready = 1'b0;
      cs_begin();
      for (int b = 1; b <= 5; b++) send_byte(8'(b));
      cs_end();
      chk("ovf_level", 32'(fifo_level), 32'h4);
      chk("ovf_flag", 32'(overflow), 32'h1);
      rx_ready = 1'b1;
      tick(8);
      rx_ready = 1'b0;
      exp_log = {8'h01, 8'h02, 8'h03, 8'h04};
      check_log("ovf_drain");
      chk("ovf_sticky", 32'(overflow), 32'h1);

      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(2);
      chk("ovf_cleared", 32'(overflow), 32'h0);

      // Full FIFO, push coincides with a single pop
      cs_begin();
      for (int b = 8'h10; b <= 8'h13; b++) send_byte(8'(b));
      for (int i = 7; i >= 1; i--) spi_bit(1'(8'h99 >> i));
      spi_mosi = 1'b1;
      tick(4);
      spi_sclk = 1'b1;
      tick(2);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
      spi_sclk = 1'b0;
      cs_end();
      chk("coincide_level", 32'(fifo_level), 32'h4);
      chk("coincide_ovf", 32'(overflow), 32'h0);
      rx_ready = 1'b1;
      tick(8);
      rx_ready = 1'b0;
      exp_log = {8'h10, 8'h11, 8'h12, 8'h13, 8'h99};
      check_log("coincide");

      // Reset mid-byte with two bytes queued
      cs_begin();
      send_byte(8'h21);
      send_byte(8'h22);
      spi_bit(1'b1); spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b0);
      f0 = n_ferr;
      rst = 1'b1;
      tick(1);
      check_reset_outputs("midrst");
      rst = 1'b0;
      cs_end();
      chk("midrst_ferr_pulses", n_ferr - f0, 0);
      rx_ready = 1'b1;
      tick(8);
      exp_log.delete();
      check_log("midrst");

      // MISO echo of the previous byte during the next one
`ifdef SPI_RX_ECHO_EN
      exp_echo = 8'h5A;
`else
      exp_echo = 8'h00;
`endif
      cs_begin();
      send_byte(8'h5A);
      send_byte_cap(8'h00, cap);
      cs_end();
      chk("miso_second_byte", 32'(cap), 32'(exp_echo));
      exp_log = {8'h5A, 8'h00};
      check_log("echo");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
